// File: rtl/fv_lv_pkt_pkg.sv
// Shared constants and types for the fv/lv CSI-2 header request generator.
package fv_lv_pkt_pkg;

  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;
  localparam logic [5:0] DT_LS = 6'h02;
  localparam logic [5:0] DT_LE = 6'h03;

  localparam int NUM_EV = 5;

  // Index order is the emit priority: lowest index wins.
  typedef enum logic [2:0] {
    EV_LE = 3'd0,
    EV_FE = 3'd1,
    EV_FS = 3'd2,
    EV_LS = 3'd3,
    EV_DH = 3'd4
  } ev_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } st_e;

  typedef struct packed {
    logic [7:0]  di;
    logic [15:0] wc;
    logic        lng;
  } hdr_t;

  function automatic ev_e pick_ev(input logic [NUM_EV-1:0] p);
    pick_ev = EV_DH;
    for (int i = NUM_EV - 1; i >= 0; i--)
      if (p[i]) pick_ev = ev_e'(i[2:0]);
  endfunction

endpackage

// File: rtl/fv_lv_edge_det.sv
// Registers fv/lv once and produces rise/fall strobes against the registered copy.
module fv_lv_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic fv,
  input  logic lv,
  output logic fv_lvl,
  output logic lv_lvl,
  output logic fv_rise,
  output logic fv_fall,
  output logic lv_rise,
  output logic lv_fall
);

  logic fv_q, fv_d, lv_q, lv_d, armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q  <= 1'b0;
      fv_d  <= 1'b0;
      lv_q  <= 1'b0;
      lv_d  <= 1'b0;
      armed <= 1'b0;
    end else begin
      fv_q  <= fv;
      fv_d  <= fv_q;
      lv_q  <= lv;
      lv_d  <= lv_q;
      armed <= armed | ~fv;
    end
  end

  // A frame already open when reset releases is not a real rise; wait for fv low first.
  assign fv_lvl  = fv_q;
  assign lv_lvl  = lv_q;
  assign fv_rise = armed & fv_q & ~fv_d;
  assign fv_fall = fv_d & ~fv_q;
  assign lv_rise = lv_q & ~lv_d;
  assign lv_fall = lv_d & ~lv_q;

endmodule

// File: rtl/fv_lv_pkt_gen.sv
// Turns fv/lv timing into CSI-2 FS/FE/LS/LE/data header requests with a ready handshake.
// LS/LE short packets are built only when FV_LV_LINE_SYNC_PKT_EN is defined.
module fv_lv_pkt_gen
  import fv_lv_pkt_pkg::*;
#(
  parameter int          H_ACTIVE      = 1280,
  parameter int          BPP           = 16,
  parameter logic [5:0]  DATA_TYPE     = 6'h1E,
  parameter logic [1:0]  VC            = 2'd0,
  parameter logic [15:0] FRAME_NUM_MAX = 16'hFFFF
) (
  input  logic        pix_clk,
  input  logic        pix_rst_n,
  input  logic        fv_i,
  input  logic        lv_i,
  input  logic        pkt_ready_i,
  output logic        pkt_valid_o,
  output logic [7:0]  pkt_di_o,
  output logic [15:0] pkt_wc_o,
  output logic        pkt_long_o,
  output logic        err_ovf_o,
  output logic        err_len_o,
  output logic        err_seq_o
);

  localparam logic [15:0] WC    = 16'(H_ACTIVE * BPP / 8);
  localparam logic [15:0] H_CNT = 16'(H_ACTIVE);

  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge pix_clk or negedge pix_rst_n) begin
    if (!pix_rst_n) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic fv_lvl, lv_lvl, fv_rise, fv_fall, lv_rise, lv_fall;

  fv_lv_edge_det u_edge (
    .clk     (pix_clk),
    .rst_n   (rst_n),
    .fv      (fv_i),
    .lv      (lv_i),
    .fv_lvl  (fv_lvl),
    .lv_lvl  (lv_lvl),
    .fv_rise (fv_rise),
    .fv_fall (fv_fall),
    .lv_rise (lv_rise),
    .lv_fall (lv_fall)
  );

  logic        in_frame, line_open, first_fs;
  logic        line_go, line_end;
  logic [15:0] frame_num, pix_cnt;

  // fv_rise counts as in-frame so a same-cycle fv/lv rise opens the line.
  assign line_go  = lv_rise & fv_lvl & (in_frame | fv_rise);
  assign line_end = lv_fall & line_open;

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame  <= 1'b0;
      line_open <= 1'b0;
      first_fs  <= 1'b1;
      frame_num <= 16'd1;
      pix_cnt   <= 16'd0;
    end else begin
      if (fv_rise) begin
        in_frame <= 1'b1;
        first_fs <= 1'b0;
        if (!first_fs)
          frame_num <= (frame_num == FRAME_NUM_MAX) ? 16'd1 : frame_num + 16'd1;
      end else if (fv_fall) begin
        in_frame <= 1'b0;
      end
      if (line_go)      line_open <= 1'b1;
      else if (lv_fall) line_open <= 1'b0;
      if (lv_rise)                         pix_cnt <= 16'd1;
      else if (lv_lvl && pix_cnt != '1)    pix_cnt <= pix_cnt + 16'd1;
    end
  end

`ifdef FV_LV_LINE_SYNC_PKT_EN
  logic [15:0] line_num;
  logic        line_first;

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      line_num   <= 16'd1;
      line_first <= 1'b1;
    end else if (fv_rise) begin
      line_num   <= 16'd1;
      line_first <= ~line_go;
    end else if (line_go) begin
      if (line_first) line_first <= 1'b0;
      else            line_num   <= line_num + 16'd1;
    end
  end
`endif

  logic [NUM_EV-1:0] pend, set, clr;
  logic              hs, ovf;
  st_e               state, state_nxt;
  ev_e               sel, sel_q;
  hdr_t              hdr_sel, hdr_q;

  always_comb begin
    set        = '0;
    set[EV_FS] = fv_rise;
    set[EV_FE] = fv_fall & in_frame;
    set[EV_DH] = line_go;
`ifdef FV_LV_LINE_SYNC_PKT_EN
    set[EV_LS] = line_go;
    set[EV_LE] = line_end;
`endif
  end

  assign hs = (state == ST_PRESENT) & pkt_ready_i;

  always_comb begin
    clr = '0;
    if (hs) clr[sel_q] = 1'b1;
  end

  // A bit being retired this cycle may be re-armed without counting as overflow.
  assign ovf = |(set & pend & ~clr);

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      err_ovf_o <= 1'b0;
      err_len_o <= 1'b0;
      err_seq_o <= 1'b0;
    end else begin
      pend      <= (pend & ~clr) | set;
      err_ovf_o <= ovf;
      err_len_o <= line_end & (pix_cnt != H_CNT);
      err_seq_o <= lv_rise & ~fv_lvl;
    end
  end

  always_comb begin
    sel     = pick_ev(pend);
    hdr_sel = '0;
    case (sel)
      EV_FS: begin hdr_sel.di = {VC, DT_FS}; hdr_sel.wc = frame_num; end
      EV_FE: begin hdr_sel.di = {VC, DT_FE}; hdr_sel.wc = frame_num; end
`ifdef FV_LV_LINE_SYNC_PKT_EN
      EV_LS: begin hdr_sel.di = {VC, DT_LS}; hdr_sel.wc = line_num; end
      EV_LE: begin hdr_sel.di = {VC, DT_LE}; hdr_sel.wc = line_num; end
`endif
      default: begin
        hdr_sel.di  = {VC, DATA_TYPE};
        hdr_sel.wc  = WC;
        hdr_sel.lng = 1'b1;
      end
    endcase
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel_q <= EV_DH;
      hdr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && |pend) begin
        sel_q <= sel;
        hdr_q <= hdr_sel;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (|pend)       state_nxt = ST_PRESENT;
      ST_PRESENT: if (pkt_ready_i) state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pkt_valid_o = (state == ST_PRESENT);
    pkt_di_o    = hdr_q.di;
    pkt_wc_o    = hdr_q.wc;
    pkt_long_o  = hdr_q.lng;
  end

endmodule

// File: tb/tb_fv_lv_pkt_gen.sv
// Self-checking bench for fv_lv_pkt_gen: frame-level packet model plus directed corner cases.
module tb_fv_lv_pkt_gen;

  localparam int          H     = 1280;
  localparam logic [15:0] WCV   = 16'd2560;
  localparam logic [5:0]  DTYPE = 6'h1E;
  localparam int          FMAX  = 3;
  localparam int          GAP   = 24;
  localparam logic [5:0]  T_FS = 6'h00, T_FE = 6'h01, T_LS = 6'h02, T_LE = 6'h03;

  logic        clk = 1'b0;
  logic        pix_rst_n, fv, lv, pkt_ready_i;
  logic        pkt_valid_o, pkt_long_o, err_ovf_o, err_len_o, err_seq_o;
  logic [7:0]  pkt_di_o;
  logic [15:0] pkt_wc_o;
  logic [24:0] cur_hdr;

  fv_lv_pkt_gen #(
    .H_ACTIVE(H), .BPP(16), .DATA_TYPE(DTYPE), .VC(2'd0), .FRAME_NUM_MAX(16'(FMAX))
  ) dut (
    .pix_clk(clk), .pix_rst_n(pix_rst_n), .fv_i(fv), .lv_i(lv),
    .pkt_ready_i(pkt_ready_i), .pkt_valid_o(pkt_valid_o), .pkt_di_o(pkt_di_o),
    .pkt_wc_o(pkt_wc_o), .pkt_long_o(pkt_long_o), .err_ovf_o(err_ovf_o),
    .err_len_o(err_len_o), .err_seq_o(err_seq_o)
  );

  always #5 clk = ~clk;
  assign cur_hdr = {pkt_di_o, pkt_wc_o, pkt_long_o};

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n_ovf = 0, n_len = 0, n_seq = 0, exp_len = 0;
  int fn = 0, low_run = 0;
  bit fn_first = 1'b1, rand_rdy = 1'b0;
  logic [24:0] obs_q[$], exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Sample away from the rising edge; also verify headers hold while stalled.
  logic pv = 1'b0, pr = 1'b0, prst = 1'b0;
  logic [24:0] ph = '0;
  always @(negedge clk) begin
    if (pix_rst_n && prst && pv && !pr) begin
      check("hold_valid", 32'(pkt_valid_o), 32'd1);
      check("hold_hdr", 32'(cur_hdr), 32'(ph));
    end
    if (pix_rst_n && pkt_valid_o && pkt_ready_i) obs_q.push_back(cur_hdr);
    if (err_ovf_o) n_ovf++;
    if (err_len_o) n_len++;
    if (err_seq_o) n_seq++;
    pv = pkt_valid_o; pr = pkt_ready_i; ph = cur_hdr; prst = pix_rst_n;
  end

  function automatic logic [24:0] mk(input logic [5:0] dt, input logic [15:0] wc, input logic lng);
    return {2'b00, dt, wc, lng};
  endfunction

  function automatic void next_fn();
    if (fn_first) begin fn = 1; fn_first = 1'b0; end
    else fn = (fn == FMAX) ? 1 : fn + 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_rdy) begin
        if (low_run >= 2 || $urandom_range(0, 2) != 0) begin pkt_ready_i = 1'b1; low_run = 0; end
        else begin pkt_ready_i = 1'b0; low_run++; end
      end
    end
  endtask

  // One frame of nl lines; model pushes the packet list the frame must produce.
  task automatic frame(input int nl, input bit al_s, input bit al_e, input bit rnd, input int len0);
    int len;
    next_fn();
    exp_q.push_back(mk(T_FS, 16'(fn), 1'b0));
    fv = 1'b1;
    for (int l = 0; l < nl; l++) begin
      len = H;
      if (rnd) case ($urandom_range(0, 3)) 0: len = H - 1; 1: len = H + 1; default: len = H; endcase
      if (l == 0 && len0 != 0) len = len0;
      if (!(l == 0 && al_s)) tick(GAP);
      lv = 1'b1; tick(len); lv = 1'b0;
`ifdef FV_LV_LINE_SYNC_PKT_EN
      exp_q.push_back(mk(T_LS, 16'(l + 1), 1'b0));
`endif
      exp_q.push_back(mk(DTYPE, WCV, 1'b1));
`ifdef FV_LV_LINE_SYNC_PKT_EN
      exp_q.push_back(mk(T_LE, 16'(l + 1), 1'b0));
`endif
      if (len != H) exp_len++;
    end
    if (!(nl > 0 && al_e)) tick(GAP);
    fv = 1'b0; tick(GAP);
    exp_q.push_back(mk(T_FE, 16'(fn), 1'b0));
  endtask

  task automatic cmp_pkts(input string tag);
    tick(8);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check(tag, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (pkt_valid_o !== 1'b1 && k < 50) begin tick(1); k++; end
    check(tag, 32'(pkt_valid_o), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] h0;
    int c_fs, c_fe, c_ls, c_le, c_dh;
    pix_rst_n = 1'b0; fv = 1'b0; lv = 1'b0; pkt_ready_i = 1'b1;
    tick(3);
    check("rst_valid", 32'(pkt_valid_o), 32'd0);
    check("rst_di",    32'(pkt_di_o),    32'd0);
    check("rst_wc",    32'(pkt_wc_o),    32'd0);
    check("rst_long",  32'(pkt_long_o),  32'd0);
    check("rst_ovf",   32'(err_ovf_o),   32'd0);
    check("rst_len",   32'(err_len_o),   32'd0);
    check("rst_seq",   32'(err_seq_o),   32'd0);
    pix_rst_n = 1'b1; tick(5);

    // Two nominal frames of three full lines.
    frame(3, 0, 0, 0, 0); frame(3, 0, 0, 0, 0);
    cmp_pkts("nominal");
    check("nominal_len", 32'(n_len), 32'(exp_len));

    // Same-cycle rises/falls, with a 1279-pixel first line.
    frame(2, 1, 1, 0, H - 1);
    cmp_pkts("aligned");
    check("short_line_len", 32'(n_len), 32'(exp_len));

    // Randomised frames under bounded random backpressure.
    rand_rdy = 1'b1;
    repeat (6) frame($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 0);
    rand_rdy = 1'b0; pkt_ready_i = 1'b1;
    cmp_pkts("random");
    check("random_len", 32'(n_len), 32'(exp_len));
    check("random_ovf", 32'(n_ovf), 32'd0);

    // lv pulse outside a frame.
    lv = 1'b1; tick(5); lv = 1'b0; tick(GAP);
    check("seq_pulse", 32'(n_seq), 32'd1);
    cmp_pkts("seq");

    // Stall a header for 10 cycles while a second line starts.
    next_fn();
    pkt_ready_i = 1'b0; fv = 1'b1;
    wait_valid("ovf_wait");
    h0 = cur_hdr;
    check("ovf_held_fs", 32'(h0), 32'(mk(T_FS, 16'(fn), 1'b0)));
    lv = 1'b1; tick(3); lv = 1'b0; tick(1); lv = 1'b1; tick(6);
    check("ovf_hold_v", 32'(pkt_valid_o), 32'd1);
    check("ovf_hold_h", 32'(cur_hdr), 32'(h0));
    pkt_ready_i = 1'b1; tick(60); lv = 1'b0; tick(GAP); fv = 1'b0; tick(GAP);
    c_fs = 0; c_fe = 0; c_ls = 0; c_le = 0; c_dh = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i][0]) c_dh++;
      else case (obs_q[i][22:17])
        T_FS: c_fs++;
        T_FE: c_fe++;
        T_LS: c_ls++;
        T_LE: c_le++;
        default: ;
      endcase
    end
    obs_q.delete();
    exp_len += 2;
    check("ovf_pulse", 32'(n_ovf), 32'd1);
    check("ovf_n_fs", 32'(c_fs), 32'd1);
    check("ovf_n_dh", 32'(c_dh), 32'd1);
    check("ovf_n_fe", 32'(c_fe), 32'd1);
`ifdef FV_LV_LINE_SYNC_PKT_EN
    check("ovf_n_ls", 32'(c_ls), 32'd1);
    check("ovf_n_le", 32'(c_le), 32'd2);
`else
    check("ovf_n_ls", 32'(c_ls), 32'd0);
    check("ovf_n_le", 32'(c_le), 32'd0);
`endif
    check("ovf_len", 32'(n_len), 32'(exp_len));

    // Reset while a header is presented, mid-line.
    pkt_ready_i = 1'b0; fv = 1'b1; tick(4); lv = 1'b1;
    wait_valid("rst_wait");
    pix_rst_n = 1'b0; #1;
    check("rst_mid_valid", 32'(pkt_valid_o), 32'd0);
    tick(3); pix_rst_n = 1'b1; pkt_ready_i = 1'b1;
    tick(50); lv = 1'b0; tick(GAP); fv = 1'b0; tick(GAP);
    fn_first = 1'b1;
    cmp_pkts("rst_mid");

    // Frame number wrap after reset: 1,2,3,1,2.
    repeat (5) frame(0, 0, 0, 0, 0);
    cmp_pkts("wrap");

    check("final_len", 32'(n_len), 32'(exp_len));
    check("final_ovf", 32'(n_ovf), 32'd1);
    check("final_seq", 32'(n_seq), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
